// File: rtl/dpic_commit_tracer_pkg.sv
// Shared difftest types plus the reference-model entry points used by the DPI tracer blocks.
// The function bodies stand in for the C side so the tracer can be elaborated on its own.
package npc_difftest_pkg;
  localparam int DT_XLEN   = 64;
  localparam int DT_NR_GPR = 32;

  typedef struct packed {
    logic [DT_XLEN-1:0]                  pc;
    logic [31:0]                         inst;
    logic [DT_NR_GPR-1:0][DT_XLEN-1:0]   gpr;
  } commit_rec_t;

  typedef enum logic [1:0] {RUN, DONE, ERR} tr_state_e;

  // Reference-model state: call log, mismatch injection, and C-side backpressure.
  int unsigned step_calls;
  int unsigned halt_calls;
  int unsigned mis_at;
  bit          drain_hold;
  logic [DT_XLEN-1:0] halt_code_seen;
  logic [63:0]        halt_cnt_seen;
  logic [DT_XLEN-1:0] pc_log[$];
  logic [31:0]        inst_log[$];
  logic [DT_NR_GPR-1:0][DT_XLEN-1:0] gpr_log[$];

  function automatic int dpic_difftest_step(input logic [DT_XLEN-1:0] pc,
                                            input logic [31:0] inst,
                                            input logic [DT_NR_GPR-1:0][DT_XLEN-1:0] gpr);
    step_calls++;
    pc_log.push_back(pc);
    inst_log.push_back(inst);
    gpr_log.push_back(gpr);
    return (step_calls == mis_at) ? 1 : 0;
  endfunction

  function automatic void dpic_halt(input logic [DT_XLEN-1:0] code, input logic [63:0] cnt);
    halt_calls++;
    halt_code_seen = code;
    halt_cnt_seen  = cnt;
  endfunction
endpackage

// File: rtl/dpic_commit_tracer_if.sv
// Commit port between the writeback stage (master) and the difftest tracer (slave).
interface dpic_commit_tracer_if #(
    parameter int XLEN   = 64,
    parameter int NR_GPR = 32
);
    logic                   commit_valid;
    logic                   commit_ready;
    logic [XLEN-1:0]        commit_pc;
    logic [31:0]            commit_inst;
    logic [NR_GPR*XLEN-1:0] gpr_flat;
    logic                   halt;
    logic [XLEN-1:0]        halt_code;

    modport master (output commit_valid, commit_pc, commit_inst, gpr_flat, halt, halt_code,
                    input  commit_ready);
    modport slave  (input  commit_valid, commit_pc, commit_inst, gpr_flat, halt, halt_code,
                    output commit_ready);
endinterface

// File: rtl/dpic_rec_fifo.sv
// Generic record FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module dpic_rec_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr, occ;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign occ     = wr_ptr - rd_ptr;
    assign cnt     = CNT_W'(occ);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/dpic_commit_tracer.sv
// Difftest commit tracer: buffers retired-instruction snapshots and checks one per cycle
// against the reference model, reporting halt, mismatch and backpressure to the core.
module dpic_commit_tracer
    import npc_difftest_pkg::*;
#(
    parameter int XLEN   = DT_XLEN,
    parameter int NR_GPR = DT_NR_GPR,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH+1)
) (
    input  logic                 clk,
    input  logic                 rst,
    dpic_commit_tracer_if.slave  cif,
    output logic [CNT_W-1:0]     fifo_cnt,
    output logic [63:0]          commit_cnt,
    output logic                 diff_err,
    output logic                 sim_done
);
    localparam int REC_W = $bits(commit_rec_t);

    tr_state_e       state_q, state_d;
    commit_rec_t     in_rec, head_rec;
    logic [REC_W-1:0] head_bits;
    logic            full, empty, push, pop, halt_fire;
    logic            halt_pend_q;
    logic [XLEN-1:0] halt_code_q;

    // x0 is architecturally zero; never trust whatever the regfile array holds there.
    always_comb begin
        in_rec      = '0;
        in_rec.pc   = cif.commit_pc;
        in_rec.inst = cif.commit_inst;
        for (int i = 1; i < NR_GPR; i++) in_rec.gpr[i] = cif.gpr_flat[i*XLEN +: XLEN];
    end

    assign head_rec  = commit_rec_t'(head_bits);
    assign push      = cif.commit_valid && cif.commit_ready;
    assign pop       = (state_q == RUN) && !empty && !drain_hold;
    assign halt_fire = (state_q == RUN) && halt_pend_q && empty;

    dpic_rec_fifo #(.DEPTH(DEPTH), .W(REC_W), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_rec),
        .dout  (head_bits),
        .full  (full),
        .empty (empty),
        .cnt   (fifo_cnt)
    );

    always_comb begin
        state_d          = state_q;
        cif.commit_ready = 1'b0;
        case (state_q)
            RUN: begin
                cif.commit_ready = rst && !full && !halt_pend_q;
                if (halt_fire) state_d = DONE;
            end
            default: ;
        endcase
    end

    // Mismatch is only known once the model has been called, so it overrides state_d here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            halt_pend_q <= 1'b0;
            halt_code_q <= '0;
            commit_cnt  <= '0;
            diff_err    <= 1'b0;
            sim_done    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push && cif.halt) begin
                halt_pend_q <= 1'b1;
                halt_code_q <= cif.halt_code;
            end
            if (pop) begin
                if (dpic_difftest_step(head_rec.pc, head_rec.inst, head_rec.gpr) == 0) begin
                    commit_cnt <= commit_cnt + 64'd1;
                end else begin
                    diff_err <= 1'b1;
                    state_q  <= ERR;
                end
            end
            if (halt_fire) begin
                dpic_halt(halt_code_q, commit_cnt);
                sim_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dpic_commit_tracer.sv
// Directed bench for dpic_commit_tracer: drain, backpressure, wrap, mismatch, halt and async reset.
module tb_dpic_commit_tracer;
    import npc_difftest_pkg::*;

    localparam int XLEN = 64, NR_GPR = 32, DEPTH = 4, CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dpic_commit_tracer_if #(.XLEN(XLEN), .NR_GPR(NR_GPR)) cif();
    logic [CNT_W-1:0] fifo_cnt;
    logic [63:0]      commit_cnt;
    logic             diff_err, sim_done;

    dpic_commit_tracer #(.XLEN(XLEN), .NR_GPR(NR_GPR), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cif(cif),
        .fifo_cnt(fifo_cnt), .commit_cnt(commit_cnt), .diff_err(diff_err), .sim_done(sim_done)
    );

    int passed = 0, total = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic h);
        cif.commit_valid = v;
        cif.commit_pc    = pc;
        cif.commit_inst  = {pc[15:0], 16'h0413};
        cif.halt         = h;
    endtask

    function automatic logic [63:0] pc_at(input int i);
        return (pc_log.size() > i) ? pc_log[i] : 64'hx;
    endfunction

    task automatic clear_model();
        step_calls = 0;
        halt_calls = 0;
        mis_at     = 0;
        drain_hold = 1'b0;
        halt_code_seen = 64'hffff;
        halt_cnt_seen  = 64'hffff;
        pc_log.delete();
        inst_log.delete();
        gpr_log.delete();
    endtask

    task automatic do_reset();
        drive(1'b0, 64'h0, 1'b0);
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        #4 rst = 1'b1;
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mx;
        bit rdy_all;
        logic [NR_GPR-1:0][XLEN-1:0] g;

        drive(1'b0, 64'h0, 1'b0);
        cif.halt_code = '0;
        for (int i = 0; i < NR_GPR; i++)
            cif.gpr_flat[i*XLEN +: XLEN] = (i == 0) ? 64'hdead : 64'h1000 + 64'(i);
        clear_model();

        // Reset state while rst is held low
        #3;
        chk("rst_ready", cif.commit_ready, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_commit_cnt", commit_cnt, 0);
        chk("rst_diff_err", diff_err, 0);
        chk("rst_sim_done", sim_done, 0);
        @(posedge clk);
        #4 rst = 1'b1;
        tick();
        chk("post_rst_ready", cif.commit_ready, 1);

        // Single commit
        drive(1'b1, 64'h80000000, 1'b0);
        tick();
        chk("t1_cnt_after_push", fifo_cnt, 1);
        chk("t1_no_call_yet", step_calls, 0);
        drive(1'b0, 64'h0, 1'b0);
        tick();
        chk("t1_cnt_drained", fifo_cnt, 0);
        chk("t1_commit_cnt", commit_cnt, 1);
        chk("t1_diff_err", diff_err, 0);
        chk("t1_calls", step_calls, 1);
        chk("t1_pc", pc_at(0), 64'h80000000);
        chk("t1_inst", (inst_log.size() > 0) ? {32'h0, inst_log[0]} : 64'hx, 64'h00000413);
        g = (gpr_log.size() > 0) ? gpr_log[0] : 'x;
        chk("t1_gpr0_forced", g[0], 0);
        chk("t1_gpr31", g[31], 64'h101f);

        // Burst of 10 with model keeping up
        do_reset();
        mx = 0;
        rdy_all = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 64'h80000100 + 64'(k*4), 1'b0);
            if (!cif.commit_ready) rdy_all = 1'b0;
            tick();
            if (int'(fifo_cnt) > mx) mx = int'(fifo_cnt);
        end
        drive(1'b0, 64'h0, 1'b0);
        tick();
        chk("t2_max_cnt", 64'(mx), 1);
        chk("t2_ready_held", rdy_all, 1);
        chk("t2_commit_cnt", commit_cnt, 10);
        chk("t2_cnt_empty", fifo_cnt, 0);

        // Model stalled: fill, then release and stream through with pointer wrap
        do_reset();
        drain_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 64'h80000200 + 64'(k*4), 1'b0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0);
        chk("t3_full_cnt", fifo_cnt, 4);
        chk("t3_full_ready", cif.commit_ready, 0);
        chk("t3_no_calls", step_calls, 0);
        drain_hold = 1'b0;
        chk("t3_ready_still_low", cif.commit_ready, 0);
        drive(1'b1, 64'h80000210, 1'b0);
        tick();
        chk("t3_cnt_after_pop", fifo_cnt, 3);
        chk("t3_ready_back", cif.commit_ready, 1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 64'h80000210 + 64'(k*4), 1'b0);
            tick();
        end
        chk("t3_cnt_steady", fifo_cnt, 3);
        drive(1'b0, 64'h0, 1'b0);
        repeat (3) tick();
        chk("t3_cnt_drained", fifo_cnt, 0);
        chk("t3_commit_cnt", commit_cnt, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t3_order_%0d", i), pc_at(i), 64'h80000200 + 64'(i*4));

        // Mismatch on the third record
        do_reset();
        mis_at = 3;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 64'h80000300 + 64'(k*4), 1'b0);
            tick();
            if (k == 2) chk("t4_no_err_yet", diff_err, 0);
        end
        chk("t4_diff_err", diff_err, 1);
        chk("t4_commit_cnt", commit_cnt, 2);
        chk("t4_ready", cif.commit_ready, 0);
        chk("t4_frozen_cnt", fifo_cnt, 1);
        chk("t4_calls", step_calls, 3);
        drive(1'b1, 64'h80000400, 1'b0);
        repeat (3) tick();
        drive(1'b0, 64'h0, 1'b0);
        chk("t4_calls_after", step_calls, 3);
        chk("t4_cnt_after", fifo_cnt, 1);
        chk("t4_commit_after", commit_cnt, 2);

        // Halt behind two queued records
        do_reset();
        drain_hold = 1'b1;
        drive(1'b1, 64'h80000008, 1'b0);
        tick();
        drive(1'b1, 64'h8000000c, 1'b0);
        tick();
        cif.halt_code = 64'h0;
        drive(1'b1, 64'h80000010, 1'b1);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        chk("t5_queued", fifo_cnt, 3);
        chk("t5_ready_halt_pend", cif.commit_ready, 0);
        drain_hold = 1'b0;
        repeat (3) tick();
        chk("t5_calls", step_calls, 3);
        chk("t5_commit_cnt", commit_cnt, 3);
        chk("t5_not_done_yet", sim_done, 0);
        chk("t5_no_halt_yet", halt_calls, 0);
        tick();
        chk("t5_sim_done", sim_done, 1);
        chk("t5_halt_calls", halt_calls, 1);
        chk("t5_halt_cnt", halt_cnt_seen, 3);
        chk("t5_halt_code", halt_code_seen, 0);
        repeat (3) tick();
        chk("t5_halt_once", halt_calls, 1);
        chk("t5_ready_done", cif.commit_ready, 0);
        chk("t5_last_pc", pc_at(2), 64'h80000010);

        // Asynchronous reset with three records queued
        do_reset();
        drive(1'b1, 64'h80000500, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        tick();
        chk("t6_pre_commit_cnt", commit_cnt, 1);
        drain_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 64'h80000600 + 64'(k*4), 1'b0);
            tick();
        end
        drive(1'b0, 64'h0, 1'b0);
        chk("t6_queued", fifo_cnt, 3);
        drain_hold = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("t6_async_cnt", fifo_cnt, 0);
        chk("t6_async_ready", cif.commit_ready, 0);
        chk("t6_async_commit_cnt", commit_cnt, 0);
        chk("t6_async_diff_err", diff_err, 0);
        @(posedge clk);
        #1;
        chk("t6_no_call_in_reset", step_calls, 1);
        #3 rst = 1'b1;
        tick();
        chk("t6_ready_after", cif.commit_ready, 1);
        drive(1'b1, 64'h80000700, 1'b0);
        tick();
        drive(1'b0, 64'h0, 1'b0);
        tick();
        chk("t6_commit_cnt", commit_cnt, 1);
        chk("t6_calls", step_calls, 2);
        chk("t6_pc", pc_at(1), 64'h80000700);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
